pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 29 ++
 rtl/pc_fetch_unit_if.sv | 19 +
 rtl/pc_fetch_unit_pc_next_mux.sv | 35 +++
 rtl/pc_fetch_unit.sv | 86 ++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
// Holds the FSM state enum, reset defaults and label offset helper.
package pc_fetch_unit_pkg;

    localparam int PC_W = 16;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t DEF_RESET_PC = 16'h0000;
    localparam pc_t DEF_HLT_WORD = 16'hE001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // Signed label offset: 11-bit for JMP, 8-bit for branches.
    function automatic pc_t label_off(
        input logic [10:0] lbl,
        input logic        jmp
    );
        pc_t off;
        if (jmp) off = {{(PC_W-11){lbl[10]}}, lbl};
        else     off = {{(PC_W-8){lbl[7]}}, lbl[7:0]};
        return off;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and the imem.
// Read is combinational: rdata follows addr in the same cycle.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    pc_t imem_addr;
    pc_t imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational next-PC selection for the RUN state.
// Priority: halt hold > Rd > Rm > label > sequential.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
(
    input  pc_t         pc,
    input  logic [10:0] label,
    input  logic        jmp,
    input  logic        flag_HLT,
    input  logic        flag_Rd_PC,
    input  logic        flag_Rm_PC,
    input  logic        flag_label_PC,
    input  pc_t         rm_data,
    input  pc_t         rd_data,
    output pc_t         pc_plus1,
    output pc_t         pc_next
);

    pc_t lbl_target;

    assign pc_plus1   = pc + pc_t'(1);
    assign lbl_target = pc_plus1 + label_off(label, jmp);

    always_comb begin
        pc_next = pc_plus1;
        priority case (1'b1)
            flag_HLT:      pc_next = pc;
            flag_Rd_PC:    pc_next = rd_data;
            flag_Rm_PC:    pc_next = rm_data;
            flag_label_PC: pc_next = lbl_target;
            default:       pc_next = pc_plus1;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch FSM and retired-instruction counter.
// Fetch is zero-latency: imem_addr is PC, Instruction is imem_rdata.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter pc_t RESET_PC = DEF_RESET_PC,
    parameter pc_t HLT_WORD = DEF_HLT_WORD
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic             resume,
    input  logic             flag_HLT,
    input  logic             flag_label_PC,
    input  logic             flag_Rm_PC,
    input  logic             flag_Rd_PC,
    input  logic             JMP,
    input  pc_t              Rm_data,
    input  pc_t              Rd_data,
    pc_fetch_unit_if.master  imem,
    output pc_t              Instruction,
    output pc_t              PC,
    output pc_t              PC_plus1,
    output logic             running,
    output logic             halted,
    output pc_t              inst_count
);

    fetch_state_t state;
    pc_t          pc_q;
    pc_t          cnt_q;
    pc_t          pc_next;
    pc_t          pc_inc;

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALT);

    assign imem.imem_addr = pc_q;
    assign Instruction    = running ? imem.imem_rdata : HLT_WORD;

    assign PC         = pc_q;
    assign PC_plus1   = pc_inc;
    assign inst_count = cnt_q;

    pc_next_mux u_mux (
        .pc            (pc_q),
        .label         (Instruction[10:0]),
        .jmp           (JMP),
        .flag_HLT      (flag_HLT),
        .flag_Rd_PC    (flag_Rd_PC),
        .flag_Rm_PC    (flag_Rm_PC),
        .flag_label_PC (flag_label_PC),
        .rm_data       (Rm_data),
        .rd_data       (Rd_data),
        .pc_plus1      (pc_inc),
        .pc_next       (pc_next)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= ST_IDLE;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) state <= ST_RUN;
                end
                ST_RUN: begin
                    pc_q <= pc_next;
                    // Counter saturates rather than wrapping.
                    if (cnt_q != '1) cnt_q <= cnt_q + pc_t'(1);
                    if (flag_HLT) state <= ST_HALT;
                end
                ST_HALT: begin
                    if (resume) begin
                        state <= ST_RUN;
                        pc_q  <= pc_inc;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
